count_frame_check: RTL and testbench

COUNT_FRAME_CHECK -- requirements
Module: count_frame_check

---
 rtl/count_frame_check_if.sv | 24 ++
 rtl/count_frame_check.sv | 136 +++++++++++++
 tb/tb_count_frame_check.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/count_frame_check_if.sv
// Stream bundle for count_frame_check: tagged input beats in, framed beats out.
interface count_frame_check_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  s_axis_tvalid;
    logic [DATA_WIDTH-1:0] s_axis_tdata;
    logic [15:0]           s_axis_count;
    logic                  s_axis_final_cnt;
    logic                  s_axis_tready;
    logic                  m_axis_tvalid;
    logic [DATA_WIDTH-1:0] m_axis_tdata;
    logic                  m_axis_tlast;
    logic                  m_axis_tready;

    modport master (
        output s_axis_tvalid, s_axis_tdata, s_axis_count, s_axis_final_cnt, m_axis_tready,
        input  s_axis_tready, m_axis_tvalid, m_axis_tdata, m_axis_tlast
    );

    modport slave (
        input  s_axis_tvalid, s_axis_tdata, s_axis_count, s_axis_final_cnt, m_axis_tready,
        output s_axis_tready, m_axis_tvalid, m_axis_tdata, m_axis_tlast
    );
endinterface

// File: rtl/count_frame_check.sv
// Checks upstream beat-index tags against an expected counter, forwards in-sequence
// beats through one register stage and drops/flags out-of-sequence ones.
//
// state | meaning
// HUNT  | waiting for a consistent count-0 beat; everything else dropped silently
// LOCK  | tracking exp_cnt; mismatches raise seq_err
module count_frame_check #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 sync_reset,
    count_frame_check_if.slave   bus,
    input  logic [15:0]          cnt_limit,
    output logic                 locked,
    output logic                 seq_err,
    output logic [15:0]          err_cnt,
    output logic [15:0]          frame_cnt
);
    typedef enum logic {HUNT = 1'b0, LOCK = 1'b1} state_t;

    state_t                state_q, state_d;
    logic                  rst_hold_q;
    logic                  m_valid_q, m_valid_d;
    logic [DATA_WIDTH-1:0] m_data_q, m_data_d;
    logic                  m_last_q, m_last_d;
    logic [15:0]           exp_cnt_q, exp_cnt_d;
    logic [15:0]           err_cnt_q, err_cnt_d;
    logic [15:0]           frame_cnt_q, frame_cnt_d;
    logic                  seq_err_q, seq_err_d;
    logic                  locked_q;
    logic                  accept, consistent, is_start, is_match;
    logic                  fwd, err_hit;

    // Held high from reset assertion until the first edge after release,
    // so the release edge itself can never accept a beat.
    always_ff @(posedge clk or posedge sync_reset) begin
        if (sync_reset) rst_hold_q <= 1'b1;
        else            rst_hold_q <= 1'b0;
    end

    assign bus.s_axis_tready = ~rst_hold_q & (~m_valid_q | bus.m_axis_tready);
    assign accept     = bus.s_axis_tvalid & bus.s_axis_tready;
    assign consistent = bus.s_axis_final_cnt == (bus.s_axis_count == cnt_limit);
    assign is_start   = consistent & (bus.s_axis_count == 16'd0);
    assign is_match   = consistent & (bus.s_axis_count == exp_cnt_q);

    always_ff @(posedge clk or posedge sync_reset) begin
        if (sync_reset) begin
            state_q  <= HUNT;
            locked_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            locked_q <= (state_d == LOCK);
        end
    end

    always_comb begin
        state_d = state_q;
        if (accept) begin
            case (state_q)
                HUNT:    if (is_start) state_d = LOCK;
                LOCK:    if (!is_match && !is_start) state_d = HUNT;
                default: state_d = HUNT;
            endcase
        end
    end

    always_comb begin
        fwd     = 1'b0;
        err_hit = 1'b0;
        if (accept) begin
            case (state_q)
                HUNT: fwd = is_start;
                LOCK: begin
                    fwd     = is_match | is_start;
                    err_hit = ~is_match;
                end
                default: fwd = 1'b0;
            endcase
        end
    end

    // Any forwarded beat is either exp_cnt or a restart at 0, so the next
    // expected index is simply its count plus one (or 0 after a final beat).
    always_comb begin
        m_valid_d   = m_valid_q;
        m_data_d    = m_data_q;
        m_last_d    = m_last_q;
        exp_cnt_d   = exp_cnt_q;
        frame_cnt_d = frame_cnt_q;
        err_cnt_d   = err_cnt_q;
        seq_err_d   = err_hit;
        if (fwd) begin
            m_valid_d = 1'b1;
            m_data_d  = bus.s_axis_tdata;
            m_last_d  = bus.s_axis_final_cnt;
            if (bus.s_axis_final_cnt) begin
                exp_cnt_d   = 16'd0;
                frame_cnt_d = frame_cnt_q + 16'd1;
            end else begin
                exp_cnt_d   = bus.s_axis_count + 16'd1;
            end
        end else if (bus.m_axis_tready) begin
            m_valid_d = 1'b0;
        end
        if (err_hit && (err_cnt_q != 16'hFFFF)) err_cnt_d = err_cnt_q + 16'd1;
    end

    always_ff @(posedge clk or posedge sync_reset) begin
        if (sync_reset) begin
            m_valid_q   <= 1'b0;
            m_data_q    <= '0;
            m_last_q    <= 1'b0;
            exp_cnt_q   <= 16'd0;
            frame_cnt_q <= 16'd0;
            err_cnt_q   <= 16'd0;
            seq_err_q   <= 1'b0;
        end else begin
            m_valid_q   <= m_valid_d;
            m_data_q    <= m_data_d;
            m_last_q    <= m_last_d;
            exp_cnt_q   <= exp_cnt_d;
            frame_cnt_q <= frame_cnt_d;
            err_cnt_q   <= err_cnt_d;
            seq_err_q   <= seq_err_d;
        end
    end

    assign bus.m_axis_tvalid = m_valid_q;
    assign bus.m_axis_tdata  = m_data_q;
    assign bus.m_axis_tlast  = m_last_q;
    assign locked            = locked_q;
    assign seq_err           = seq_err_q;
    assign err_cnt           = err_cnt_q;
    assign frame_cnt         = frame_cnt_q;
endmodule

// File: tb/tb_count_frame_check.sv
// Directed bench for count_frame_check: vector table plus hand-written reset,
// cnt_limit=0 and error-saturation sequences.
module tb_count_frame_check;
    logic        clk = 1'b0;
    logic        sync_reset;
    logic [15:0] cnt_limit;
    logic        locked, seq_err;
    logic [15:0] err_cnt, frame_cnt;
    int          n_tests = 0;
    int          n_fail  = 0;

    always #5 clk = ~clk;

    count_frame_check_if #(.DATA_WIDTH(32)) bus ();

    count_frame_check #(.DATA_WIDTH(32)) dut (
        .clk        (clk),
        .sync_reset (sync_reset),
        .bus        (bus),
        .cnt_limit  (cnt_limit),
        .locked     (locked),
        .seq_err    (seq_err),
        .err_cnt    (err_cnt),
        .frame_cnt  (frame_cnt)
    );

    typedef struct {
        logic        v;
        logic [15:0] cnt;
        logic        fin;
        logic [31:0] d;
        logic        mrdy;
        logic        e_srdy;
        logic        e_mv;
        logic [31:0] e_md;
        logic        e_ml;
        logic        e_err;
        logic        e_lock;
        logic [15:0] e_fc;
        logic [15:0] e_ec;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic v, input logic [15:0] cnt, input logic fin,
                                input logic [31:0] d, input logic mrdy, input logic e_srdy,
                                input logic e_mv, input logic [31:0] e_md, input logic e_ml,
                                input logic e_err, input logic e_lock,
                                input logic [15:0] e_fc, input logic [15:0] e_ec);
        vec_t r;
        r.v = v; r.cnt = cnt; r.fin = fin; r.d = d; r.mrdy = mrdy;
        r.e_srdy = e_srdy; r.e_mv = e_mv; r.e_md = e_md; r.e_ml = e_ml;
        r.e_err = e_err; r.e_lock = e_lock; r.e_fc = e_fc; r.e_ec = e_ec;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [15:0] cnt, input logic fin,
                         input logic [31:0] d, input logic mrdy);
        bus.s_axis_tvalid    = v;
        bus.s_axis_count     = cnt;
        bus.s_axis_final_cnt = fin;
        bus.s_axis_tdata     = d;
        bus.m_axis_tready    = mrdy;
    endtask

    task automatic apply(input string tag, input vec_t x);
        drive(x.v, x.cnt, x.fin, x.d, x.mrdy);
        #1;
        chk({tag, " s_tready"}, {31'b0, bus.s_axis_tready}, {31'b0, x.e_srdy});
        @(posedge clk);
        #1;
        chk({tag, " m_tvalid"}, {31'b0, bus.m_axis_tvalid}, {31'b0, x.e_mv});
        if (x.e_mv) begin
            chk({tag, " m_tdata"}, bus.m_axis_tdata, x.e_md);
            chk({tag, " m_tlast"}, {31'b0, bus.m_axis_tlast}, {31'b0, x.e_ml});
        end
        chk({tag, " seq_err"},   {31'b0, seq_err},   {31'b0, x.e_err});
        chk({tag, " locked"},    {31'b0, locked},    {31'b0, x.e_lock});
        chk({tag, " frame_cnt"}, {16'b0, frame_cnt}, {16'b0, x.e_fc});
        chk({tag, " err_cnt"},   {16'b0, err_cnt},   {16'b0, x.e_ec});
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, " m_tvalid"},  {31'b0, bus.m_axis_tvalid}, 32'd0);
        chk({tag, " m_tdata"},   bus.m_axis_tdata, 32'd0);
        chk({tag, " m_tlast"},   {31'b0, bus.m_axis_tlast}, 32'd0);
        chk({tag, " seq_err"},   {31'b0, seq_err}, 32'd0);
        chk({tag, " locked"},    {31'b0, locked}, 32'd0);
        chk({tag, " err_cnt"},   {16'b0, err_cnt}, 32'd0);
        chk({tag, " frame_cnt"}, {16'b0, frame_cnt}, 32'd0);
    endtask

    initial begin
        sync_reset = 1'b1;
        cnt_limit  = 16'd3;
        drive(1'b0, 16'd0, 1'b0, 32'd0, 1'b1);
        #2;
        chk_zero("reset");
        repeat (2) @(posedge clk);
        @(negedge clk) sync_reset = 1'b0;
        @(posedge clk);
        #1;
        chk("post_reset s_tready", {31'b0, bus.s_axis_tready}, 32'd1);

        // hunt: 2,3 dropped, then 0..3 forwarded
        tbl.push_back(mk(1, 2, 0, 32'h01, 1,  1, 0, 32'h00, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 3, 1, 32'h02, 1,  1, 0, 32'h00, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 32'h03, 1,  1, 1, 32'h03, 0, 0, 1, 0, 0));
        tbl.push_back(mk(1, 1, 0, 32'h04, 1,  1, 1, 32'h04, 0, 0, 1, 0, 0));
        tbl.push_back(mk(1, 2, 0, 32'h05, 1,  1, 1, 32'h05, 0, 0, 1, 0, 0));
        tbl.push_back(mk(1, 3, 1, 32'h06, 1,  1, 1, 32'h06, 1, 0, 1, 1, 0));
        // two clean frames
        tbl.push_back(mk(1, 0, 0, 32'h07, 1,  1, 1, 32'h07, 0, 0, 1, 1, 0));
        tbl.push_back(mk(1, 1, 0, 32'h08, 1,  1, 1, 32'h08, 0, 0, 1, 1, 0));
        tbl.push_back(mk(1, 2, 0, 32'h09, 1,  1, 1, 32'h09, 0, 0, 1, 1, 0));
        tbl.push_back(mk(1, 3, 1, 32'h0A, 1,  1, 1, 32'h0A, 1, 0, 1, 2, 0));
        tbl.push_back(mk(1, 0, 0, 32'h0B, 1,  1, 1, 32'h0B, 0, 0, 1, 2, 0));
        tbl.push_back(mk(1, 1, 0, 32'h0C, 1,  1, 1, 32'h0C, 0, 0, 1, 2, 0));
        tbl.push_back(mk(1, 2, 0, 32'h0D, 1,  1, 1, 32'h0D, 0, 0, 1, 2, 0));
        tbl.push_back(mk(1, 3, 1, 32'h0E, 1,  1, 1, 32'h0E, 1, 0, 1, 3, 0));
        tbl.push_back(mk(0, 0, 0, 32'h00, 1,  1, 0, 32'h00, 0, 0, 1, 3, 0));
        // gap 0,1,3 then relock
        tbl.push_back(mk(1, 0, 0, 32'h10, 1,  1, 1, 32'h10, 0, 0, 1, 3, 0));
        tbl.push_back(mk(1, 1, 0, 32'h11, 1,  1, 1, 32'h11, 0, 0, 1, 3, 0));
        tbl.push_back(mk(1, 3, 1, 32'h12, 1,  1, 0, 32'h00, 0, 1, 0, 3, 1));
        tbl.push_back(mk(1, 0, 0, 32'h13, 1,  1, 1, 32'h13, 0, 0, 1, 3, 1));
        // early restart, then flag error
        tbl.push_back(mk(1, 1, 0, 32'h14, 1,  1, 1, 32'h14, 0, 0, 1, 3, 1));
        tbl.push_back(mk(1, 0, 0, 32'h15, 1,  1, 1, 32'h15, 0, 1, 1, 3, 2));
        tbl.push_back(mk(1, 3, 0, 32'h16, 1,  1, 0, 32'h00, 0, 1, 0, 3, 3));
        tbl.push_back(mk(0, 0, 0, 32'h00, 1,  1, 0, 32'h00, 0, 0, 0, 3, 3));
        // backpressure: 5 stalled cycles, then a second short stall
        tbl.push_back(mk(1, 0, 0, 32'h20, 1,  1, 1, 32'h20, 0, 0, 1, 3, 3));
        for (int k = 0; k < 5; k++)
            tbl.push_back(mk(1, 1, 0, 32'h21, 0,  0, 1, 32'h20, 0, 0, 1, 3, 3));
        tbl.push_back(mk(1, 1, 0, 32'h21, 1,  1, 1, 32'h21, 0, 0, 1, 3, 3));
        tbl.push_back(mk(1, 2, 0, 32'h22, 0,  0, 1, 32'h21, 0, 0, 1, 3, 3));
        tbl.push_back(mk(1, 2, 0, 32'h22, 1,  1, 1, 32'h22, 0, 0, 1, 3, 3));
        tbl.push_back(mk(1, 3, 1, 32'h23, 1,  1, 1, 32'h23, 1, 0, 1, 4, 3));
        tbl.push_back(mk(0, 0, 0, 32'h00, 1,  1, 0, 32'h00, 0, 0, 1, 4, 3));

        foreach (tbl[i]) apply($sformatf("row%0d", i), tbl[i]);

        // async reset mid-frame, off the clock edge
        apply("ar_f0", mk(1, 0, 0, 32'h30, 1,  1, 1, 32'h30, 0, 0, 1, 4, 3));
        apply("ar_f1", mk(1, 1, 0, 32'h31, 1,  1, 1, 32'h31, 0, 0, 1, 4, 3));
        drive(1'b1, 16'd0, 1'b0, 32'h33, 1'b1);
        #2 sync_reset = 1'b1;
        #1;
        chk_zero("async_reset");
        @(posedge clk);
        @(negedge clk) sync_reset = 1'b0;
        @(posedge clk);
        #1;
        chk("release_edge m_tvalid", {31'b0, bus.m_axis_tvalid}, 32'd0);
        chk("release_edge locked", {31'b0, locked}, 32'd0);
        apply("ar_drop", mk(1, 2, 0, 32'h32, 1,  1, 0, 32'h00, 0, 0, 0, 0, 0));
        apply("ar_s0",   mk(1, 0, 0, 32'h33, 1,  1, 1, 32'h33, 0, 0, 1, 0, 0));
        apply("ar_s1",   mk(1, 1, 0, 32'h34, 1,  1, 1, 32'h34, 0, 0, 1, 0, 0));
        apply("ar_flag", mk(1, 3, 0, 32'h35, 1,  1, 0, 32'h00, 0, 1, 0, 0, 1));

        // cnt_limit = 0: every consistent count-0 beat is a whole frame
        cnt_limit = 16'd0;
        apply("lim0_a", mk(1, 0, 1, 32'h40, 1,  1, 1, 32'h40, 1, 0, 1, 1, 1));
        apply("lim0_b", mk(1, 0, 1, 32'h41, 1,  1, 1, 32'h41, 1, 0, 1, 2, 1));
        apply("lim0_c", mk(1, 0, 1, 32'h42, 1,  1, 1, 32'h42, 1, 0, 1, 3, 1));
        apply("lim0_bad", mk(1, 0, 0, 32'h43, 1, 1, 0, 32'h00, 0, 1, 0, 3, 2));

        // saturation: repeated count-0 restarts in LOCK, each one an error
        cnt_limit = 16'd3;
        drive(1'b1, 16'd0, 1'b0, 32'h50, 1'b1);
        repeat (65533) @(posedge clk);
        #1;
        chk("sat err_cnt FFFE", {16'b0, err_cnt}, 32'h0000_FFFE);
        chk("sat locked", {31'b0, locked}, 32'd1);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            chk($sformatf("sat%0d err_cnt", k), {16'b0, err_cnt}, 32'h0000_FFFF);
            chk($sformatf("sat%0d seq_err", k), {31'b0, seq_err}, 32'd1);
        end
        drive(1'b0, 16'd0, 1'b0, 32'h0, 1'b1);
        @(posedge clk);
        #1;
        chk("sat idle seq_err", {31'b0, seq_err}, 32'd0);
        chk("sat idle err_cnt", {16'b0, err_cnt}, 32'h0000_FFFF);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
